uart_tx_link: RTL and testbench

- Byte-serial transmitter for the board-to-board link; the send side of the serial connection.
- Accepts one-cycle byte strobes from the connection/handshake FSM and game logic, e.g. the 0x90–0x93 handshake codes.
- Buffers the bytes in a small FIFO and serializes them as 8N1 UART frames on TxD, LSB first.
- Its TxD output feeds the physical wire to the peer board's receiver.

---
 rtl/uart_tx_link.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_link.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_link.sv
// Byte-serial 8N1 UART transmitter with a small write FIFO for the board-to-board link.
// Optional even-parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_tx_link #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD        = 115_200,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] DataIn,
  input  logic       send_data,
  output logic       TxD,
  output logic       busy,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int BIT_TICKS = CLK_FREQ_HZ / BAUD;
  localparam int TICK_W    = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = PTR_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP
`ifdef UART_TX_PARITY_EN
    , PARITY
`endif
  } state_e;

  state_e             state_q, state_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shreg_q, shreg_d;
  logic               txd_q, txd_d;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q;
  logic [7:0]         mem_q [FIFO_DEPTH];

  logic bit_end, fifo_empty, full, pop, wr_en;

  assign bit_end    = (tick_q == TICK_W'(BIT_TICKS - 1));
  assign fifo_empty = (count_q == '0);
  assign full       = (count_q == CNT_W'(FIFO_DEPTH));
  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign wr_en      = send_data && (!full || pop);

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    pop     = 1'b0;
    if (state_q != IDLE) tick_d = bit_end ? '0 : tick_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_d = mem_q[rd_ptr_q];
          tick_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shreg_d = mem_q[rd_ptr_q];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level follows the current state, so TxD lags state changes by one cycle.
  always_comb begin
    txd_d = 1'b1;
    case (state_q)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shreg_q[bit_q];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_d = ^shreg_q;
`endif
      default: txd_d = 1'b1;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      txd_q    <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      txd_q   <= txd_d;
      count_q <= count_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      if (send_data && !wr_en) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= DataIn;
  end

  assign TxD       = txd_q;
  assign busy      = (state_q != IDLE) || !fifo_empty;
  assign fifo_full = full;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_uart_tx_link.sv
// Self-checking bench for uart_tx_link: directed frame table, multi-cycle corner sequences,
// and randomized traffic checked cycle by cycle against a frame-timeline reference model.
module tb_uart_tx_link;

  localparam int BT    = 10;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int F    = BT * NB;
  localparam int HMAX = 16384;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       send_data = 1'b0;
  logic [7:0] DataIn = '0;
  logic       TxD, busy, fifo_full, overflow;

  uart_tx_link #(.CLK_FREQ_HZ(1000), .BAUD(100), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .DataIn(DataIn), .send_data(send_data),
    .TxD(TxD), .busy(busy), .fifo_full(fifo_full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic txd_hist [HMAX];
  logic busy_hist[HMAX];
  logic full_hist[HMAX];
  logic ovf_hist [HMAX];

  // Reference model: each accepted byte gets the edge at which it leaves the FIFO;
  // its line frame occupies the F edges that follow.
  logic [7:0] q_d[$];
  int         q_p[$];
  logic       m_ovf = 1'b0;

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, c, act, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  task automatic model_edge(input logic r, input logic sd, input logic [7:0] d);
    int   e;
    int   cnt;
    int   p;
    logic popnow;
    e = cyc;
    cnt = 0;
    popnow = 1'b0;
    if (r) begin
      q_d.delete();
      q_p.delete();
      m_ovf = 1'b0;
      return;
    end
    while (q_p.size() > 0 && q_p[0] + F <= e) begin
      void'(q_p.pop_front());
      void'(q_d.pop_front());
    end
    foreach (q_p[i]) begin
      if (q_p[i] >= e) cnt++;
      if (q_p[i] == e) popnow = 1'b1;
    end
    if (sd) begin
      if (cnt < DEPTH || popnow) begin
        p = e + 1;
        if (q_p.size() > 0 && q_p[$] + F > p) p = q_p[$] + F;
        q_p.push_back(p);
        q_d.push_back(d);
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic step(input logic r, input logic sd, input logic [7:0] d);
    logic exp_txd, exp_busy, exp_full;
    int   inq;
    reset = r;
    send_data = sd;
    DataIn = d;
    @(posedge clk);
    cyc++;
    model_edge(r, sd, d);
    #1;
    exp_txd = 1'b1;
    inq = 0;
    foreach (q_p[i]) begin
      if (cyc >= q_p[i] + 1 && cyc <= q_p[i] + F) exp_txd = frame_bit(q_d[i], (cyc - q_p[i] - 1) / BT);
      if (q_p[i] > cyc) inq++;
    end
    exp_busy = (q_p.size() > 0);
    exp_full = (inq == DEPTH);
    chk("txd", cyc, TxD, exp_txd);
    chk("busy", cyc, busy, exp_busy);
    chk("fifo_full", cyc, fifo_full, exp_full);
    chk("overflow", cyc, overflow, m_ovf);
    if (cyc < HMAX) begin
      txd_hist[cyc]  = TxD;
      busy_hist[cyc] = busy;
      full_hist[cyc] = fifo_full;
      ovf_hist[cyc]  = overflow;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic check_frame(input string nm, input int s, input logic [7:0] exp);
    logic [7:0] got;
    chk({nm, "_start"}, s, txd_hist[s + BT/2], 1'b0);
    for (int i = 0; i < 8; i++) got[i] = txd_hist[s + BT*(1+i) + BT/2];
    chk({nm, "_byte"}, s, got, exp);
`ifdef UART_TX_PARITY_EN
    chk({nm, "_parity"}, s, txd_hist[s + BT*9 + BT/2], ^exp);
`endif
    chk({nm, "_stop"}, s, txd_hist[s + BT*(NB-1) + BT/2], 1'b1);
  endtask

  typedef struct {
    logic [7:0] din;
    logic [7:0] line_bits;
    logic       par;
  } vec_t;

  initial begin
    vec_t tbl[6];
    int   n, rr, toggles, dens;
    logic rst_r, sd_r;

    tbl[0] = '{8'h90, 8'b1001_0000, 1'b0};
    tbl[1] = '{8'h93, 8'b1001_0011, 1'b0};
    tbl[2] = '{8'h92, 8'b1001_0010, 1'b1};
    tbl[3] = '{8'h55, 8'b0101_0101, 1'b0};
    tbl[4] = '{8'h00, 8'b0000_0000, 1'b0};
    tbl[5] = '{8'h01, 8'b0000_0001, 1'b1};

    // Reset, then a quiet line.
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    idle(50);

    // Single frames from the table.
    for (int t = 0; t < 6; t++) begin
      n = cyc + 1;
      step(1'b0, 1'b1, tbl[t].din);
      idle(F + 12);
      chk("latency_pre", n + 1, txd_hist[n+1], 1'b1);
      chk("start_first", n + 2, txd_hist[n+2], 1'b0);
      chk("start_last", n + 1 + BT, txd_hist[n+1+BT], 1'b0);
      for (int i = 0; i < 8; i++)
        chk("data_bit", n + 2 + BT*(1+i), txd_hist[n + 2 + BT*(1+i) + BT/2], tbl[t].line_bits[i]);
`ifdef UART_TX_PARITY_EN
      chk("parity_bit", n + 2 + BT*9, txd_hist[n + 2 + BT*9 + BT/2], tbl[t].par);
`endif
      chk("stop_bit", n + 2 + BT*(NB-1), txd_hist[n + 2 + BT*(NB-1) + BT/2], 1'b1);
      chk("busy_last", n + F, busy_hist[n+F], 1'b1);
      chk("busy_fall", n + F + 1, busy_hist[n+F+1], 1'b0);
    end

    // Back-to-back handshake bytes.
    n = cyc + 1;
    step(1'b0, 1'b1, 8'h91);
    step(1'b0, 1'b1, 8'h92);
    step(1'b0, 1'b1, 8'h93);
    idle(3*F + 10);
    for (int k = 0; k < 3; k++) check_frame("b2b", n + 2 + k*F, 8'(8'h91 + k));
    chk("b2b_stop_end", n + 1 + F, txd_hist[n+1+F], 1'b1);
    chk("b2b_next_start", n + 2 + F, txd_hist[n+2+F], 1'b0);
    chk("b2b_busy_last", n + 3*F, busy_hist[n+3*F], 1'b1);
    chk("b2b_busy_fall", n + 3*F + 1, busy_hist[n+3*F+1], 1'b0);

    // Overflow, then a write into a full FIFO on the same edge as a pop.
    n = cyc + 1;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'(8'hA0 + i));
    idle(n + F - cyc);
    step(1'b0, 1'b1, 8'hA6);
    idle(6*F + 10);
    chk("full_before", n + 3, full_hist[n+3], 1'b0);
    chk("full_set", n + 4, full_hist[n+4], 1'b1);
    chk("ovf_before", n + 4, ovf_hist[n+4], 1'b0);
    chk("ovf_set", n + 5, ovf_hist[n+5], 1'b1);
    chk("full_wr_pop", n + 1 + F, full_hist[n+1+F], 1'b1);
    for (int k = 0; k < 5; k++) check_frame("ovf_line", n + 2 + k*F, 8'(8'hA0 + k));
    check_frame("wr_pop_line", n + 2 + 5*F, 8'hA6);
    chk("ovf_busy_fall", n + 1 + 6*F, busy_hist[n+1+6*F], 1'b0);
    chk("ovf_sticky", cyc, ovf_hist[cyc], 1'b1);

    // Reset in the middle of a frame with a second byte queued.
    n = cyc + 1;
    step(1'b0, 1'b1, 8'h55);
    step(1'b0, 1'b1, 8'h66);
    rr = n + 2 + 45;
    idle(rr - 1 - cyc);
    step(1'b1, 1'b0, 8'h00);
    idle(200);
    chk("rst_pre_txd", rr - 1, txd_hist[rr-1], 1'b0);
    chk("rst_pre_ovf", rr - 1, ovf_hist[rr-1], 1'b1);
    chk("rst_txd", rr, txd_hist[rr], 1'b1);
    chk("rst_busy", rr, busy_hist[rr], 1'b0);
    chk("rst_full", rr, full_hist[rr], 1'b0);
    chk("rst_ovf", rr, ovf_hist[rr], 1'b0);
    toggles = 0;
    for (int c = rr + 1; c <= rr + 200; c++) if (txd_hist[c] !== txd_hist[c-1]) toggles++;
    chk("rst_quiet_line", rr, toggles, 0);
    chk("rst_flushed", rr + 200, busy_hist[rr+200], 1'b0);

    // Randomized traffic with varying density and rare resets.
    dens = 40;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) begin
        case ($urandom_range(0, 3))
          0: dens = 2;
          1: dens = 10;
          2: dens = 60;
          default: dens = 300;
        endcase
      end
      rst_r = ($urandom_range(0, 1999) == 0);
      sd_r  = ($urandom_range(0, dens - 1) == 0);
      step(rst_r, sd_r, 8'($urandom));
    end
    idle(6*F);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
